uart_rx_unit: RTL and testbench

16x-oversampling UART receiver that sits on the serial line and delivers bytes to the CPU-side UART register block. It mirrors the transmit path and runs on the system clock. It uses the baud generator's tick as a one-cycle sample enable rather than as a clock. A one-entry holding register with a read-acknowledge handshake decouples byte arrival from CPU reads, and the block flags framing and overrun errors.

---
 rtl/uart_rx_unit.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit.sv
// 16x-oversampling UART receiver with a one-entry holding register and read-acknowledge handshake.
// Optional even-parity stage is compiled in when UART_RX_PARITY_EN is defined; otherwise parity_err is tied low.
module uart_rx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_en,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t          state;
  logic [4:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shift;
  logic            rx_meta;
  logic            rs;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      dout         <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      // NOTE: pulse defaults low every cycle; only the frame-completion branch raises it.
      rx_done_tick <= 1'b0;

      // A read consumes the held byte; a simultaneous load below overrides rx_valid.
      if (rd_en && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rs) begin
            state <= START;
            s     <= '0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == 5'd7) begin
              if (!rs) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == 5'd15) begin
              s     <= '0;
              shift <= {rs, shift[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == 5'd15) begin
              par_bit <= rs;
              state   <= STOP;
              s       <= '0;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            if (s == 5'(SB_TICK - 1)) begin
              state        <= IDLE;
              dout         <= shift;
              frame_err    <= ~rs;
              rx_valid     <= 1'b1;
              rx_done_tick <= 1'b1;
              // Overwriting an unread byte is only an overrun if the CPU is not reading it now.
              if (rx_valid && !rd_en) begin
                overrun <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              parity_err <= (^shift) ^ par_bit;
`endif
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: frame-level model with per-cycle output comparison.
// Frames are timed against a free-running 1-in-4 s_tick; build with UART_RX_PARITY_EN to exercise parity.
module tb_uart_rx_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rd_en;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  uart_rx_unit #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rd_en        (rd_en),
    .dout         (dout),
    .rx_valid     (rx_valid),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_seen = 0;
  logic rd_q = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    int         cyc;
  } frame_t;

  frame_t pending[$];

  // Model of the CPU-visible holding register
  logic [7:0] m_dout;
  logic       m_valid, m_ferr, m_perr, m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_q <= rd_en;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Compare process: model applies frame completions and reads, then every output is checked.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        m_dout = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
        pending.delete();
      end else if (rx_done_tick === 1'b1) begin
        done_seen++;
        check("done_expected", 32'(pending.size() != 0), 32'd1);
        if (pending.size() != 0) begin
          f = pending.pop_front();
          check("done_cycle", cyc, f.cyc);
          if (m_valid && !rd_q) m_ovr = 1'b1;
          else if (m_valid && rd_q) m_ovr = 1'b0;
          m_valid = 1'b1;
          m_dout  = f.data;
          m_ferr  = ~f.stop;
`ifdef UART_RX_PARITY_EN
          m_perr  = (^f.data) ^ f.par;
`else
          m_perr  = 1'b0;
`endif
        end
      end else if (rd_q && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      check("dout", dout, m_dout);
      check("rx_valid", rx_valid, m_valid);
      check("frame_err", frame_err, m_ferr);
      check("parity_err", parity_err, m_perr);
      check("overrun", overrun, m_ovr);
    end
  end

  task automatic sync_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
    #1;
  endtask

  // Start edge lands right after a tick edge P0; the stop bit is sampled at P0 + 64*(bits+1) + 32.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                            input logic rd_at_done);
    int     c0, d0, nbits;
    frame_t f;
    nbits = 8;
`ifdef UART_RX_PARITY_EN
    nbits = 9;
`endif
    sync_tick();
    c0 = cyc;
    d0 = done_seen;
    rx = 1'b0;
    f.data = data; f.stop = stop_bit; f.par = par_bit;
    f.cyc  = c0 + 64 * (nbits + 1) + 32;
    pending.push_back(f);
    for (int i = 0; i < nbits; i++) begin
      repeat (64) @(posedge clk);
      #1 rx = (i < 8) ? data[i] : par_bit;
    end
    repeat (64) @(posedge clk);
    #1 rx = stop_bit;
    repeat (31) @(posedge clk);
    #1 if (rd_at_done) rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    repeat (16) @(posedge clk);
    #1 rx = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("done_count", done_seen - d0, 32'd1);
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rx = 1'b1; rd_en = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("idle_busy", busy, 1'b0);

    // Reset in the middle of a frame
    sync_tick();
    rx = 1'b0;
    d0 = done_seen;
    repeat (40) @(posedge clk);
    #1 check("busy_mid_frame", busy, 1'b1);
    reset = 1'b0;
    #1 check("busy_async_reset", busy, 1'b0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (100) @(posedge clk);
    #1 check("no_done_after_reset", done_seen - d0, 32'd0);

    // Basic frame and read
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check("t2_dout", dout, 8'h55);
    check("t2_valid", rx_valid, 1'b1);
    check("t2_ferr", frame_err, 1'b0);
    pulse_rd();
    check("t2_valid_after_rd", rx_valid, 1'b0);

    // False start: 5 ticks low
    sync_tick();
    d0 = done_seen;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("false_start_busy", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("false_start_idle", busy, 1'b0);
    check("false_start_no_done", done_seen - d0, 32'd0);
    check("false_start_valid", rx_valid, 1'b0);

    // Framing error, then a good frame (unread byte makes this an overrun too)
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    check("t4_dout", dout, 8'hA3);
    check("t4_ferr", frame_err, 1'b1);
    check("t4_valid", rx_valid, 1'b1);
    check("t4_busy_after_low_stop", busy, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("t4_dout2", dout, 8'h3C);
    check("t4_ferr2", frame_err, 1'b0);
    pulse_rd();

    // Overrun, then simultaneous completion and read
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, 1'b0);
    check("t5_dout", dout, 8'h34);
    check("t5_ovr", overrun, 1'b1);
    pulse_rd();
    check("t5_valid_rd", rx_valid, 1'b0);
    check("t5_ovr_rd", overrun, 1'b0);
    send_frame(8'h56, 1'b1, 1'b0, 1'b0);
    send_frame(8'h78, 1'b1, 1'b0, 1'b1);
    check("t5_sim_dout", dout, 8'h78);
    check("t5_sim_valid", rx_valid, 1'b1);
    check("t5_sim_ovr", overrun, 1'b0);
    pulse_rd();

    // Parity: 0x07 has three ones, so even parity bit is 1
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("t6_perr_ok", parity_err, 1'b0);
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("t6_perr_bad", parity_err, 1'b1);
`else
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("t6_perr_off", parity_err, 1'b0);
`endif
    check("t6_dout", dout, 8'h07);

    // Reset clears a held byte
    reset = 1'b0;
    #1;
    check("held_cleared_valid", rx_valid, 1'b0);
    check("held_cleared_dout", dout, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
